// File: rtl/video_ram_rmw.sv
// video_ram_rmw
//   Single-port character/tile RAM shared by two clients:
//     - a video read port that always wins the memory port, and
//     - a valid/ready command port running READ, WRITE, ADD, SUB, SWAP
//       (atomic read-modify-write) and a whole-memory FILL.
//   The command FSM simply waits ("stalls") in any cycle the video port reads.
//
// Ports
//   clk        system clock, everything on posedge
//   reset      asynchronous active-low reset
//   vid_rd     video read request (may be high every cycle)
//   vid_addr   video read address
//   vid_data   video read data, valid the cycle after vid_rd, held otherwise
//   cmd_valid  command present
//   cmd_ready  IDLE and out of reset
//   cmd_op     0 READ, 1 WRITE, 2 ADD, 3 SUB, 4 SWAP, 5 FILL, 6/7 act as READ
//   cmd_addr   target address (ignored for FILL)
//   cmd_data   write value / operand / fill value
//   rsp_valid  one-cycle completion pulse
//   rsp_data   old memory word (0 for WRITE and FILL), held until next pulse
//   busy       command in progress
module video_ram_rmw #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vid_rd,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic [DATA_WIDTH-1:0] vid_data,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy
);
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_SWAP  = 3'd4;
    localparam logic [2:0] OP_FILL  = 3'd5;

    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_MODIFY, S_FILL, S_DONE} state_t;

    state_t                state_reg, state_next;
    logic [2:0]            op_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] operand_reg;
    logic [ADDR_WIDTH-1:0] fill_cnt_reg;
    logic                  vid_sel_reg;
    logic [DATA_WIDTH-1:0] vid_hold_reg;
    logic                  fsm_sel_reg;
    logic [DATA_WIDTH-1:0] old_reg;
    logic [DATA_WIDTH-1:0] rsp_hold_reg;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] ram_q;

    logic                  mem_we, mem_re, fsm_rd, accept;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata, old_data, modify_result;
    logic [DATA_WIDTH:0]   sum_ext, diff_ext;
    logic                  is_rmw, returns_old;

    // The RAM output register is shared by both clients. Each client keeps
    // its own copy: while its select flag is set the fresh RAM word is used,
    // afterwards the holding register keeps it safe from later reads.
    assign vid_data = vid_sel_reg ? ram_q : vid_hold_reg;
    assign old_data = fsm_sel_reg ? ram_q : old_reg;

    assign is_rmw      = (op_reg == OP_ADD) || (op_reg == OP_SUB) || (op_reg == OP_SWAP);
    assign returns_old = (op_reg != OP_WRITE) && (op_reg != OP_FILL);
    assign accept      = (state_reg == S_IDLE) && cmd_valid && cmd_ready;
    assign fsm_rd      = !vid_rd && (state_reg == S_ACCESS) && (op_reg != OP_WRITE);

    // Extra top bit carries the ADD carry-out / SUB borrow.
    assign sum_ext  = {1'b0, old_data} + {1'b0, operand_reg};
    assign diff_ext = {1'b0, old_data} - {1'b0, operand_reg};

    always_comb begin
        modify_result = operand_reg;
        if (op_reg == OP_ADD) begin
            modify_result = (SATURATE != 0 && sum_ext[DATA_WIDTH]) ? '1 : sum_ext[DATA_WIDTH-1:0];
        end else if (op_reg == OP_SUB) begin
            modify_result = (SATURATE != 0 && diff_ext[DATA_WIDTH]) ? '0 : diff_ext[DATA_WIDTH-1:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; every memory-touching state waits while vid_rd is high.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (accept) state_next = (cmd_op == OP_FILL) ? S_FILL : S_ACCESS;
            S_ACCESS: if (!vid_rd) state_next = is_rmw ? S_MODIFY : S_DONE;
            S_MODIFY: if (!vid_rd) state_next = S_DONE;
            S_FILL:   if (!vid_rd && fill_cnt_reg == '1) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Outputs and memory port
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = addr_reg;
        mem_wdata = operand_reg;
        if (vid_rd) begin
            mem_re   = 1'b1;
            mem_addr = vid_addr;
        end else begin
            case (state_reg)
                S_ACCESS: begin
                    if (op_reg == OP_WRITE) mem_we = 1'b1;
                    else                    mem_re = 1'b1;
                end
                S_MODIFY: begin
                    mem_we    = 1'b1;
                    mem_wdata = modify_result;
                end
                S_FILL: begin
                    mem_we   = 1'b1;
                    mem_addr = fill_cnt_reg;
                end
                default: ;
            endcase
        end
        cmd_ready = (state_reg == S_IDLE) && reset;
        busy      = (state_reg != S_IDLE);
        rsp_valid = (state_reg == S_DONE);
        rsp_data  = rsp_hold_reg;
        if (state_reg == S_DONE) rsp_data = returns_old ? old_data : '0;
    end

    // Command latches and data holding registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_reg       <= '0;
            addr_reg     <= '0;
            operand_reg  <= '0;
            fill_cnt_reg <= '0;
            vid_sel_reg  <= 1'b0;
            vid_hold_reg <= '0;
            fsm_sel_reg  <= 1'b0;
            old_reg      <= '0;
            rsp_hold_reg <= '0;
        end else begin
            vid_sel_reg  <= vid_rd;
            vid_hold_reg <= vid_data;
            fsm_sel_reg  <= fsm_rd;
            old_reg      <= old_data;
            rsp_hold_reg <= rsp_data;
            if (accept) begin
                op_reg      <= cmd_op;
                addr_reg    <= cmd_addr;
                operand_reg <= cmd_data;
            end
            // Wraps to 0 after the last address, ready for the next FILL.
            if (state_reg == S_FILL && !vid_rd) fill_cnt_reg <= fill_cnt_reg + ADDR_WIDTH'(1);
        end
    end

    // Single-port RAM with registered read; contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) ram_q <= mem[mem_addr];
    end
endmodule

// File: tb/tb_video_ram_rmw.sv
// Directed bench for video_ram_rmw: instance 0 is 8x1024 wrapping,
// instance 1 is 8x16 saturating. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_video_ram_rmw;
    localparam logic [2:0] RD = 3'd0, WR = 3'd1, ADD = 3'd2, SUB = 3'd3, SWP = 3'd4, FIL = 3'd5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      vid_rd, cmd_valid, cmd_ready, rsp_valid, busy;
    logic [1:0][9:0] vid_addr, cmd_addr;
    logic [1:0][7:0] vid_data, cmd_data, rsp_data;
    logic [1:0][2:0] cmd_op;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    video_ram_rmw #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .SATURATE(0)) u0 (
        .clk(clk), .reset(rst_n),
        .vid_rd(vid_rd[0]), .vid_addr(vid_addr[0]), .vid_data(vid_data[0]),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
        .cmd_addr(cmd_addr[0]), .cmd_data(cmd_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .busy(busy[0])
    );

    video_ram_rmw #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .SATURATE(1)) u1 (
        .clk(clk), .reset(rst_n),
        .vid_rd(vid_rd[1]), .vid_addr(vid_addr[1][3:0]), .vid_data(vid_data[1]),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
        .cmd_addr(cmd_addr[1][3:0]), .cmd_data(cmd_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command at a falling edge and follow it to its response.
    // vmask bit (c-1) raises vid_rd in cycle c after the accept edge; with
    // vchk set, vid_data must equal vexp once any such video read has landed.
    // poke drives a competing WRITE in cycles 2..5 that must not be accepted.
    task automatic do_cmd(input int d, input logic [2:0] op, input logic [9:0] addr,
                          input logic [7:0] data, input int lat, input logic [7:0] rsp,
                          input logic [31:0] vmask, input logic [9:0] vaddr,
                          input logic vchk, input logic [7:0] vexp, input logic poke,
                          input string tag);
        int c;
        logic vseen;
        cmd_valid[d] = 1'b1;
        cmd_op[d]    = op;
        cmd_addr[d]  = addr;
        cmd_data[d]  = data;
        vid_addr[d]  = vaddr;
        check({tag, "_ready"}, 32'(cmd_ready[d]), 32'd1);
        @(negedge clk);
        cmd_valid[d] = 1'b0;
        check({tag, "_busy"}, 32'(busy[d]), 32'd1);
        c = 1;
        vseen = 1'b0;
        while (!rsp_valid[d] && c < 100) begin
            if (vchk && vseen) check({tag, "_vid"}, 32'(vid_data[d]), 32'(vexp));
            vid_rd[d] = (c <= 32) ? vmask[c-1] : 1'b0;
            if (vid_rd[d]) vseen = 1'b1;
            if (poke && c >= 2 && c <= 5) begin
                cmd_valid[d] = 1'b1;
                cmd_op[d]    = WR;
                cmd_addr[d]  = 10'h003;
                cmd_data[d]  = 8'h00;
                check({tag, "_noaccept"}, 32'(cmd_ready[d]), 32'd0);
            end else begin
                cmd_valid[d] = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        vid_rd[d]    = 1'b0;
        cmd_valid[d] = 1'b0;
        check({tag, "_lat"}, 32'(c), 32'(lat));
        check({tag, "_rsp"}, 32'(rsp_data[d]), 32'(rsp));
        $display("cmd dut=%0d op=%0d addr=%0h data=%0h -> rsp=%0h after %0d cycles",
                 d, op, addr, data, rsp_data[d], c);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(rsp_valid[d]), 32'd0);
        check({tag, "_hold"}, 32'(rsp_data[d]), 32'(rsp));
    endtask

    task automatic cmd(input int d, input logic [2:0] op, input logic [9:0] addr,
                       input logic [7:0] data, input int lat, input logic [7:0] rsp,
                       input string tag);
        do_cmd(d, op, addr, data, lat, rsp, 32'h0, 10'h0, 1'b0, 8'h00, 1'b0, tag);
    endtask

    task automatic vid_read(input int d, input logic [9:0] addr, input logic [7:0] exp,
                            input string tag);
        vid_rd[d]   = 1'b1;
        vid_addr[d] = addr;
        @(negedge clk);
        vid_rd[d] = 1'b0;
        check(tag, 32'(vid_data[d]), 32'(exp));
        $display("vid dut=%0d addr=%0h -> data=%0h", d, addr, vid_data[d]);
    endtask

    initial begin
        vid_rd = '0; cmd_valid = '0; vid_addr = '0; cmd_addr = '0;
        cmd_data = '0; cmd_op = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(cmd_ready[d]), 32'd0);
            check("rst_busy", 32'(busy[d]), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check("rst_rsp_data", 32'(rsp_data[d]), 32'd0);
            check("rst_vid_data", 32'(vid_data[d]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready0", 32'(cmd_ready[0]), 32'd1);
        check("rel_ready1", 32'(cmd_ready[1]), 32'd1);

        // Wrapping instance
        cmd(0, WR, 10'h005, 8'h3C, 2, 8'h00, "wr005");
        cmd(0, RD, 10'h005, 8'h00, 2, 8'h3C, "rd005");
        vid_read(0, 10'h005, 8'h3C, "vid005");
        @(negedge clk);
        check("vid_hold", 32'(vid_data[0]), 32'h3C);
        cmd(0, ADD, 10'h005, 8'hD0, 3, 8'h3C, "add_wrap");
        cmd(0, RD, 10'h005, 8'h00, 2, 8'h0C, "rd_add_wrap");
        cmd(0, WR, 10'h006, 8'h04, 2, 8'h00, "wr006");
        cmd(0, SUB, 10'h006, 8'h10, 3, 8'h04, "sub_wrap");
        cmd(0, RD, 10'h006, 8'h00, 2, 8'hF4, "rd_sub_wrap");
        // ADD stalled four cycles in ACCESS by video reads of the same word
        do_cmd(0, ADD, 10'h005, 8'h01, 7, 8'h0C, 32'hF, 10'h005, 1'b1, 8'h0C, 1'b0, "add_stall");
        cmd(0, RD, 10'h005, 8'h00, 2, 8'h0D, "rd_add_stall");
        // Video read of the target between the RMW read and write sees old data
        do_cmd(0, ADD, 10'h005, 8'h10, 4, 8'h0D, 32'h2, 10'h005, 1'b1, 8'h0D, 1'b0, "add_atomic");
        vid_read(0, 10'h005, 8'h1D, "vid_add_atomic");
        vid_read(0, 10'h006, 8'hF4, "vid006");
        cmd(0, WR, 10'h3FF, 8'h12, 2, 8'h00, "wr3ff");
        cmd(0, SWP, 10'h3FF, 8'h77, 3, 8'h12, "swap");
        cmd(0, 3'd7, 10'h3FF, 8'h55, 2, 8'h77, "op7_read");

        // Reset while the ADD is in MODIFY: its write must not happen
        cmd(0, WR, 10'h010, 8'h40, 2, 8'h00, "wr010");
        cmd_valid[0] = 1'b1; cmd_op[0] = ADD; cmd_addr[0] = 10'h010; cmd_data[0] = 8'h05;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        @(negedge clk);
        check("midrst_busy_before", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_ready", 32'(cmd_ready[0]), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
            check("midrst_ready_low", 32'(cmd_ready[0]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_rel", 32'(cmd_ready[0]), 32'd1);
        check("midrst_no_rsp", 32'(rsp_valid[0]), 32'd0);
        cmd(0, RD, 10'h010, 8'h00, 2, 8'h40, "rd010_unchanged");

        // Saturating 16-word instance
        cmd(1, WR, 10'h005, 8'h3C, 2, 8'h00, "s_wr5");
        cmd(1, ADD, 10'h005, 8'hD0, 3, 8'h3C, "s_add_sat");
        cmd(1, RD, 10'h005, 8'h00, 2, 8'hFF, "s_rd_add_sat");
        // FILL with video reads on every other cycle: 16 writes, 16 stalls
        do_cmd(1, FIL, 10'h000, 8'hA5, 33, 8'h00, 32'h5555_5555, 10'h000, 1'b0, 8'h00, 1'b1, "fill");
        for (int i = 0; i < 16; i++) vid_read(1, 10'(i), 8'hA5, $sformatf("fill_word%0d", i));
        cmd(1, WR, 10'h006, 8'h04, 2, 8'h00, "s_wr6");
        cmd(1, SUB, 10'h006, 8'h10, 3, 8'h04, "s_sub_sat");
        cmd(1, RD, 10'h006, 8'h00, 2, 8'h00, "s_rd_sub_sat");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
